// File: rtl/bat_loader_pkg.sv
// ============================================================================
// bat_loader_pkg : shared state encoding and default frame marker
// Rev 1.0
// ============================================================================
`default_nettype none

package bat_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hBA;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CNT_H = 4'd1,
    ST_CNT_L = 4'd2,
    ST_DAT_H = 4'd3,
    ST_DAT_L = 4'd4,
    ST_WRITE = 4'd5,
    ST_CHECK = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bat_loader_xsum.sv
// ============================================================================
// bat_loader_xsum : 8-bit running XOR with synchronous clear and enable
// Rev 1.0
// ============================================================================
`default_nettype none

module bat_loader_xsum (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 8'h00;
    end else if (clr_i) begin
      sum_q <= 8'h00;
    end else if (en_i) begin
      sum_q <= sum_q ^ data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

`default_nettype wire

// File: rtl/bat_loader.sv
// ============================================================================
// bat_loader : receives a framed program image over a byte stream and writes
//              it into RAM while holding the CPU; checks a trailing XOR sum.
// Rev 1.0
// ============================================================================
`default_nettype none

module bat_loader
  import bat_loader_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  output logic                     RX_READY,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [15:0]              DATA,
  output logic                     RAM_WE,
  output logic                     CPU_HOLD,
  output logic                     DONE,
  output logic                     ERROR
);

  state_e                   state_q, state_d;
  logic [15:0]              remain_q;
  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [15:0]              data_q;
  logic [7:0]               hi_q;
  logic [7:0]               xsum;
  logic                     accept;
  logic                     xsum_clr;
  logic                     xsum_en;

  assign accept   = RX_VALID & RX_READY;
  assign xsum_clr = accept && (state_q == ST_IDLE) && (RX_DATA == SYNC_BYTE);
  assign xsum_en  = accept && ((state_q == ST_CNT_H) || (state_q == ST_CNT_L) ||
                               (state_q == ST_DAT_H) || (state_q == ST_DAT_L));

  bat_loader_xsum u_xsum (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (xsum_clr),
    .en_i   (xsum_en),
    .data_i (RX_DATA),
    .sum_o  (xsum)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (xsum_clr) state_d = ST_CNT_H;
      ST_CNT_H: if (accept) state_d = ST_CNT_L;
      ST_CNT_L: if (accept) state_d = ({remain_q[15:8], RX_DATA} == 16'd0) ? ST_CHECK : ST_DAT_H;
      ST_DAT_H: if (accept) state_d = ST_DAT_L;
      ST_DAT_L: if (accept) state_d = ST_WRITE;
      // remain_q still holds the pre-decrement count during WRITE
      ST_WRITE: state_d = (remain_q == 16'd1) ? ST_CHECK : ST_DAT_H;
      ST_CHECK: if (accept) state_d = (RX_DATA == xsum) ? ST_DONE : ST_ERR;
      ST_DONE:  state_d = ST_DONE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    RX_READY = 1'b0;
    RAM_WE   = 1'b0;
    CPU_HOLD = 1'b1;
    DONE     = 1'b0;
    ERROR    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CNT_H, ST_CNT_L, ST_DAT_H, ST_DAT_L, ST_CHECK: RX_READY = 1'b1;
      ST_WRITE: RAM_WE = 1'b1;
      ST_DONE: begin
        CPU_HOLD = 1'b0;
        DONE     = 1'b1;
      end
      ST_ERR:  ERROR = 1'b1;
      default: RX_READY = 1'b0;
    endcase
  end

  // The output address/data registers load as the LO byte is taken, so they
  // are valid during WRITE and then hold the last written word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remain_q <= 16'd0;
      ptr_q    <= '0;
      addr_q   <= '0;
      data_q   <= 16'd0;
      hi_q     <= 8'd0;
    end else begin
      if (xsum_clr) begin
        remain_q <= 16'd0;
        ptr_q    <= '0;
      end
      if (accept && (state_q == ST_CNT_H)) remain_q[15:8] <= RX_DATA;
      if (accept && (state_q == ST_CNT_L)) remain_q[7:0]  <= RX_DATA;
      if (accept && (state_q == ST_DAT_H)) hi_q <= RX_DATA;
      if (accept && (state_q == ST_DAT_L)) begin
        addr_q <= ptr_q;
        data_q <= {hi_q, RX_DATA};
      end
      if (state_q == ST_WRITE) begin
        ptr_q    <= ptr_q + 1'b1;
        remain_q <= remain_q - 16'd1;
      end
    end
  end

  assign ADDRESS = addr_q;
  assign DATA    = data_q;

endmodule

`default_nettype wire
